// File: rtl/temporizador_param.sv
// rtl/temporizador_param.sv - one-shot/periodic timer with shadowed terminal count and early warning
module temporizador_param #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] DEFAULT_TC = WIDTH'(16'hFDE8),
  parameter int               LEAD       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] tc_in,
  input  logic             tc_load,
  output logic [WIDTH-1:0] cuenta,
  output logic             tiempo,
  output logic             tx_done,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] LEAD_V = WIDTH'(LEAD);

  state_t           state, state_n;
  logic [WIDTH-1:0] cuenta_n;
  logic [WIDTH-1:0] tc_shadow;
  logic [WIDTH-1:0] active_tc, active_tc_n;
  logic [WIDTH-1:0] tc_sel;
  logic             mode_act, mode_act_n;
  logic             terminal;

  // A load in the same cycle as start/reload wins over the stale shadow value
  assign tc_sel   = tc_load ? tc_in : tc_shadow;
  assign terminal = (state == RUN) && (cuenta == active_tc);

  assign tiempo  = terminal;
  assign tx_done = (state == RUN) && (active_tc >= LEAD_V) && (cuenta == active_tc - LEAD_V);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    state_n     = state;
    cuenta_n    = cuenta;
    active_tc_n = active_tc;
    mode_act_n  = mode_act;
    if (stop) begin
      state_n  = IDLE;
      cuenta_n = '0;
    end else if (start) begin
      state_n     = RUN;
      cuenta_n    = '0;
      mode_act_n  = mode;
      active_tc_n = tc_sel;
    end else begin
      case (state)
        RUN: begin
          // Terminal cycle always ends the period, even with enable low
          if (terminal) begin
            if (mode_act) begin
              cuenta_n    = '0;
              active_tc_n = tc_sel;
            end else begin
              state_n = DONE;
            end
          end else if (enable) begin
            cuenta_n = cuenta + WIDTH'(1);
          end
        end
        IDLE:    state_n = IDLE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cuenta    <= '0;
      tc_shadow <= DEFAULT_TC;
      active_tc <= DEFAULT_TC;
      mode_act  <= 1'b0;
    end else begin
      state     <= state_n;
      cuenta    <= cuenta_n;
      active_tc <= active_tc_n;
      mode_act  <= mode_act_n;
      if (tc_load) begin
        tc_shadow <= tc_in;
      end
    end
  end

endmodule

// File: tb/tb_temporizador_param.sv
// tb/tb_temporizador_param.sv - scoreboard bench for temporizador_param
module tb_temporizador_param;

  logic        clk = 1'b0;
  logic        rst, enable, start, stop, mode, tc_load;
  logic [15:0] tc_in16;
  logic [7:0]  tc_in8;

  logic [15:0] cuenta0;
  logic        tiempo0, tx_done0, busy0, done0;
  logic [7:0]  cuenta1, cuenta2;
  logic        tiempo1, tx_done1, busy1, done1;
  logic        tiempo2, tx_done2, busy2, done2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic [15:0] cuenta;
    logic        tiempo;
    logic        tx_done;
    logic        busy;
    logic        done;
  } chk_t;

  chk_t sb[$];

  always #5 clk = ~clk;

  temporizador_param dut0 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .mode(mode),
    .tc_in(tc_in16), .tc_load(tc_load), .cuenta(cuenta0), .tiempo(tiempo0),
    .tx_done(tx_done0), .busy(busy0), .done(done0)
  );

  temporizador_param #(.WIDTH(8), .DEFAULT_TC(8'd7), .LEAD(2)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .mode(mode),
    .tc_in(tc_in8), .tc_load(tc_load), .cuenta(cuenta1), .tiempo(tiempo1),
    .tx_done(tx_done1), .busy(busy1), .done(done1)
  );

  temporizador_param #(.WIDTH(8), .DEFAULT_TC(8'd6), .LEAD(4)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .mode(mode),
    .tc_in(tc_in8), .tc_load(tc_load), .cuenta(cuenta2), .tiempo(tiempo2),
    .tx_done(tx_done2), .busy(busy2), .done(done2)
  );

  function automatic logic [19:0] obs0();
    return {cuenta0, tiempo0, tx_done0, busy0, done0};
  endfunction

  function automatic logic [19:0] obs1();
    return {8'h00, cuenta1, tiempo1, tx_done1, busy1, done1};
  endfunction

  function automatic logic [19:0] obs2();
    return {8'h00, cuenta2, tiempo2, tx_done2, busy2, done2};
  endfunction

  function automatic logic [19:0] pk(input chk_t e);
    return {e.cuenta, e.tiempo, e.tx_done, e.busy, e.done};
  endfunction

  task automatic push(input int cyc, input int cu, input bit t, input bit x, input bit b, input bit d);
    chk_t e;
    e.cyc = cyc; e.cuenta = 16'(cu); e.tiempo = t; e.tx_done = x; e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; tc_load = 1'b0; enable = 1'b0; mode = 1'b0;
    tc_in16 = '0; tc_in8 = '0;
    tick(); tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    chk_t e;
    apply_reset();
    start = 1'b1; enable = 1'b1; tick(); tick();
    rst = 1'b1; start = 1'b1; tick();
    checks++;
    if (obs0() !== 20'h0) begin errors++; $display("FAIL reset_dut0 got=%h exp=%h", obs0(), 20'h0); end
    checks++;
    if (obs1() !== 20'h0) begin errors++; $display("FAIL reset_dut1 got=%h exp=%h", obs1(), 20'h0); end
    checks++;
    if (obs2() !== 20'h0) begin errors++; $display("FAIL reset_dut2 got=%h exp=%h", obs2(), 20'h0); end
    rst = 1'b0; start = 1'b0; tick();
    checks++;
    if (obs1() !== 20'h0) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs1(), 20'h0); end
    for (int k = 0; k <= 8; k++) push(k, (k > 7) ? 7 : k, k == 7, k == 5, k <= 7, k == 8);
    start = 1'b1; mode = 1'b0; enable = 1'b1;
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs1() !== pk(e)) begin errors++; $display("FAIL reset_default_tc c=%0d got=%h exp=%h", c, obs1(), pk(e)); end
      end
      start = 1'b0;
    end
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL reset_default_tc timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  task automatic test_oneshot_default();
    chk_t e;
    apply_reset();
    push(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(64998, 64998, 1'b0, 1'b0, 1'b1, 1'b0);
    push(64999, 64999, 1'b0, 1'b1, 1'b1, 1'b0);
    push(65000, 65000, 1'b1, 1'b0, 1'b1, 1'b0);
    push(65001, 65000, 1'b0, 1'b0, 1'b0, 1'b1);
    push(65004, 65000, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1; mode = 1'b0; enable = 1'b1;
    for (int c = 0; c < 65100 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs0() !== pk(e)) begin errors++; $display("FAIL oneshot_default c=%0d got=%h exp=%h", c, obs0(), pk(e)); end
      end
      start = 1'b0;
    end
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL oneshot_default timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  task automatic test_periodic();
    chk_t e;
    apply_reset();
    for (int k = 0; k < 18; k++) push(k, k % 6, (k % 6) == 5, (k % 6) == 3, 1'b1, 1'b0);
    tc_in8 = 8'd5; tc_load = 1'b1; tick(); tc_load = 1'b0;
    start = 1'b1; mode = 1'b1; enable = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs1() !== pk(e)) begin errors++; $display("FAIL periodic c=%0d got=%h exp=%h", c, obs1(), pk(e)); end
      end
      start = 1'b0; mode = 1'b0;
    end
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL periodic timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  task automatic test_tc_reload();
    chk_t e;
    int seq[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 0, 1, 2};
    apply_reset();
    for (int k = 0; k < 12; k++)
      push(k, seq[k], k == 5 || k == 8 || k == 11, k == 3 || k == 6 || k == 9, 1'b1, 1'b0);
    tc_in8 = 8'd5; tc_load = 1'b1; tick(); tc_load = 1'b0;
    start = 1'b1; mode = 1'b1; enable = 1'b1;
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs1() !== pk(e)) begin errors++; $display("FAIL tc_reload c=%0d got=%h exp=%h", c, obs1(), pk(e)); end
      end
      start = 1'b0;
      tc_load = (c == 1);
      tc_in8 = (c == 1) ? 8'd2 : 8'd0;
    end
    tc_load = 1'b0;
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL tc_reload timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  task automatic test_enable_gap();
    chk_t e;
    int seq[8] = '{0, 1, 1, 2, 2, 3, 3, 3};
    apply_reset();
    for (int k = 0; k < 8; k++) push(k, seq[k], k == 5, k == 1 || k == 2, k <= 5, k >= 6);
    tc_in8 = 8'd3; tc_load = 1'b1; tick(); tc_load = 1'b0;
    start = 1'b1; mode = 1'b0; enable = 1'b0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs1() !== pk(e)) begin errors++; $display("FAIL enable_gap c=%0d got=%h exp=%h", c, obs1(), pk(e)); end
      end
      start = 1'b0;
      enable = (c % 2) == 0;
    end
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL enable_gap timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  task automatic test_stop_restart();
    chk_t e;
    apply_reset();
    push(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(2, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    push(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(6, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    push(7, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tc_in8 = 8'd5; tc_load = 1'b1; tick(); tc_load = 1'b0;
    start = 1'b1; mode = 1'b0; enable = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs1() !== pk(e)) begin errors++; $display("FAIL stop_restart c=%0d got=%h exp=%h", c, obs1(), pk(e)); end
      end
      stop = (c == 2);
      start = (c == 4);
      tc_load = (c == 4);
      tc_in8 = (c == 4) ? 8'd1 : 8'd0;
    end
    stop = 1'b0; start = 1'b0; tc_load = 1'b0;
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL stop_restart timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    chk_t e;
    int seq[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 4};
    apply_reset();
    for (int k = 0; k < 10; k++) push(k, seq[k], k == 3 || k == 8, k == 1 || k == 6, k <= 8, k == 9);
    tc_in8 = 8'd3; tc_load = 1'b1; tick(); tc_load = 1'b0;
    start = 1'b1; mode = 1'b1; enable = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs1() !== pk(e)) begin errors++; $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs1(), pk(e)); end
      end
      start = (c == 3);
      mode = 1'b0;
      tc_load = (c == 3);
      tc_in8 = (c == 3) ? 8'd4 : 8'd0;
    end
    start = 1'b0; tc_load = 1'b0;
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL back_to_back timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  task automatic test_lead_over_tc();
    chk_t e;
    apply_reset();
    for (int k = 0; k < 9; k++) push(k, k % 3, (k % 3) == 2, 1'b0, 1'b1, 1'b0);
    push(9, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 10; k <= 16; k++) push(k, k - 10, k == 16, k == 12, 1'b1, 1'b0);
    push(17, 6, 1'b0, 1'b0, 1'b0, 1'b1);
    tc_in8 = 8'd2; tc_load = 1'b1; tick(); tc_load = 1'b0;
    start = 1'b1; mode = 1'b1; enable = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      tick();
      if (sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs2() !== pk(e)) begin errors++; $display("FAIL lead_over_tc c=%0d got=%h exp=%h", c, obs2(), pk(e)); end
      end
      rst = (c == 8);
      start = (c == 9);
      mode = 1'b0;
    end
    rst = 1'b0; start = 1'b0;
    if (sb.size() > 0) begin errors++; checks++; $display("FAIL lead_over_tc timeout pending=%0d", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_tc_reload();
    test_enable_gap();
    test_stop_restart();
    test_back_to_back();
    test_lead_over_tc();
    test_oneshot_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temporizador_param.md
TEMPORIZADOR_PARAM -- requirements
Module: temporizador_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, all state updating on the rising edge of clk.
REQ-002 Parameter WIDTH, default 16: counter and terminal-count width in bits.
REQ-003 Parameter DEFAULT_TC, default 16'hFDE8 (65000): terminal count after reset.
REQ-004 Parameter LEAD, default 1, legal range 1..2^WIDTH-1: cycles of advance warning before terminal.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 enable  in  1  count-advance qualifier while running.
REQ-008 start  in  1  arm/restart pulse.
REQ-009 stop  in  1  abort pulse.
REQ-010 mode  in  1  0 = one-shot, 1 = periodic; sampled on start.
REQ-011 tc_in  in  WIDTH  new terminal count.
REQ-012 tc_load  in  1  write tc_in into the shadow terminal register.
REQ-013 cuenta  out  WIDTH  current count.
REQ-014 tiempo  out  1  terminal indication.
REQ-015 tx_done  out  1  early warning, LEAD cycles before terminal.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  high in DONE (one-shot finished).

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-019 Input priority SHALL be rst > stop > start > terminal handling > enable-driven increment.
REQ-020 tc_load SHALL write tc_in into tc_shadow in any state; the value only affects counting when copied into active_tc.
REQ-021 On start in any state, the FSM SHALL enter RUN with cuenta=0, mode_act=mode, and active_tc = tc_in if tc_load is high that cycle, else tc_shadow.
REQ-022 On stop in any state, the FSM SHALL enter IDLE with cuenta=0; active_tc and tc_shadow are retained.
REQ-023 In RUN with cuenta != active_tc, cuenta SHALL increment by 1 when enable=1 and hold when enable=0.
REQ-024 tiempo SHALL be combinational: (state==RUN) && (cuenta==active_tc).
REQ-025 tx_done SHALL be combinational: (state==RUN) && (active_tc >= LEAD) && (cuenta == active_tc-LEAD), with the subtraction evaluated at WIDTH bits; it SHALL never assert when active_tc < LEAD.
REQ-026 On the edge ending a terminal cycle, the transition SHALL occur regardless of enable.
REQ-027 In a periodic terminal cycle, the block SHALL set cuenta=0, reload active_tc from tc_shadow (or from tc_in if tc_load is high that cycle), and remain in RUN.
REQ-028 In a one-shot terminal cycle, the block SHALL enter DONE with cuenta held at active_tc.
REQ-029 With enable continuously high, one period SHALL last exactly active_tc+1 cycles: tiempo every active_tc+1 cycles and tx_done LEAD cycles before each tiempo.
REQ-030 active_tc=0 in periodic mode SHALL hold tiempo high every RUN cycle, with cuenta fixed at 0.
REQ-031 The counter SHALL never wrap past 2^WIDTH-1, since terminal handling occurs at cuenta==active_tc <= 2^WIDTH-1.
REQ-032 start coinciding with a terminal cycle SHALL take effect as a restart per REQ-021; tiempo is still high during that cycle.
REQ-033 Changing mode during RUN SHALL have no effect until the next start.
REQ-034 In IDLE and DONE, enable SHALL be ignored, and tiempo and tx_done SHALL be low.

Reset
REQ-035 On rst, the block SHALL set state=IDLE, cuenta=0, tc_shadow=active_tc=DEFAULT_TC and mode_act=0, leaving tiempo, tx_done, busy and done low the following cycle.
REQ-036 A rst asserted mid-RUN SHALL abort counting with no terminal indication.

Verification
REQ-037 Defaults: rst, then start with mode=0 and enable held high -> tx_done high at cuenta=64999, tiempo high at cuenta=65000 (65001st RUN cycle), then done=1, busy=0 and cuenta=65000 held.
REQ-038 WIDTH=8, LEAD=2, tc_load with tc_in=5, start with mode=1, enable high -> tiempo every 6 cycles, tx_done at cuenta=3, cuenta sequence 0..5,0..
REQ-039 Periodic run with tc=5; tc_load with tc_in=2 at cuenta=1 -> current period still ends at 5, next period ends at 2.
REQ-040 enable toggled 1,0,1,0... with tc=3, one-shot -> cuenta holds on enable=0 cycles; tiempo asserts only after 3 enabled increments.
REQ-041 stop at cuenta=2 -> IDLE, cuenta=0, no tiempo; start and tc_load with tc_in=1 in the same cycle -> tiempo after 2 enabled cycles.
REQ-042 LEAD=4 with tc=2 -> tx_done never asserts, tiempo is normal; rst mid-RUN -> all outputs low the next cycle and tc restored to DEFAULT_TC.
